// File: rtl/exec_unit_mc.sv
// Handshaked execution stage: single-cycle ALU/shift ops plus an iterative
// shift-and-add unsigned MUL that stalls upstream through in_ready.
module exec_unit_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_dec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] DM_data,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       flag_ex
);

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADI = 6'b000010,
                         OP_SBI = 6'b000011, OP_MOV = 6'b000100, OP_MVI = 6'b000101,
                         OP_NOT = 6'b000110, OP_NTI = 6'b000111, OP_AND = 6'b001000,
                         OP_ANI = 6'b001001, OP_OR  = 6'b001010, OP_ORI = 6'b001011,
                         OP_XOR = 6'b001100, OP_XRI = 6'b001101, OP_LD  = 6'b001110,
                         OP_ST  = 6'b001111, OP_IN  = 6'b010000, OP_LS  = 6'b010001,
                         OP_RS  = 6'b010010, OP_RSA = 6'b010011, OP_RET = 6'b010100,
                         OP_HLT = 6'b010101, OP_OUT = 6'b010110, OP_JMP = 6'b010111,
                         OP_JV  = 6'b011000, OP_JNV = 6'b011001, OP_JZ  = 6'b011010,
                         OP_JNZ = 6'b011011, OP_MUL = 6'b100000;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_W   = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   mcand_r, acc_r, acc_nxt_s;
  logic [WIDTH-1:0]     mplr_r;
  logic [CW-1:0]        cnt_r;

  logic [WIDTH-1:0]     res_s;
  logic [WIDTH:0]       arith_s, lsh_s, rsh_s, rsa_s;
  logic [SHW-1:0]       amt_s;
  logic                 big_s, eq_w_s;
  logic                 n_s, c_s, z_s, v_s;
  logic                 ans_upd_s, flags_upd_s, out_op_s;

  assign in_ready = (state_r == ST_IDLE);
  assign amt_s    = B[SHW-1:0];
  assign big_s    = (B > W_VAL);
  assign eq_w_s   = (B == W_VAL);

  // Single-cycle result and flag computation for the opcode on the inputs
  always_comb begin
    res_s       = {WIDTH{1'b0}};
    c_s         = 1'b0;
    v_s         = 1'b0;
    ans_upd_s   = 1'b1;
    flags_upd_s = 1'b1;
    out_op_s    = 1'b0;
    arith_s     = {(WIDTH+1){1'b0}};
    // The extra bit on each shift catches the last bit shifted out.
    lsh_s       = {1'b0, A} << amt_s;
    rsh_s       = {A, 1'b0} >> amt_s;
    rsa_s       = $signed({A, 1'b0}) >>> amt_s;
    case (op_dec)
      OP_ADD, OP_ADI: begin
        arith_s = {1'b0, A} + {1'b0, B};
        res_s   = arith_s[WIDTH-1:0];
        c_s     = arith_s[WIDTH];
        v_s     = (A[WIDTH-1] == B[WIDTH-1]) && (res_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SBI: begin
        arith_s = {1'b0, A} - {1'b0, B};
        res_s   = arith_s[WIDTH-1:0];
        c_s     = arith_s[WIDTH];
        v_s     = (A[WIDTH-1] != B[WIDTH-1]) && (res_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MOV, OP_MVI: res_s = B;
      OP_NOT, OP_NTI: res_s = ~B;
      OP_AND, OP_ANI: res_s = A & B;
      OP_OR,  OP_ORI: res_s = A | B;
      OP_XOR, OP_XRI: res_s = A ^ B;
      OP_LD,  OP_ST: begin
        res_s       = A;
        flags_upd_s = 1'b0;
      end
      OP_IN: res_s = data_in;
      OP_LS: begin
        if (big_s || eq_w_s) begin
          res_s = {WIDTH{1'b0}};
          c_s   = eq_w_s ? A[WIDTH-1] : 1'b0;
        end else begin
          res_s = lsh_s[WIDTH-1:0];
          c_s   = lsh_s[WIDTH];
        end
      end
      OP_RS, OP_RSA: begin
        if (big_s || eq_w_s) begin
          res_s = (op_dec == OP_RSA) ? {WIDTH{A[WIDTH-1]}} : {WIDTH{1'b0}};
          c_s   = eq_w_s ? A[0] : 1'b0;
        end else if (op_dec == OP_RSA) begin
          res_s = rsa_s[WIDTH:1];
          c_s   = rsa_s[0];
        end else begin
          res_s = rsh_s[WIDTH:1];
          c_s   = rsh_s[0];
        end
      end
      OP_RET, OP_HLT, OP_JMP, OP_JV, OP_JNV, OP_JZ, OP_JNZ: begin
        ans_upd_s   = 1'b0;
        flags_upd_s = 1'b0;
      end
      OP_OUT: begin
        ans_upd_s   = 1'b0;
        flags_upd_s = 1'b0;
        out_op_s    = 1'b1;
      end
      default: flags_upd_s = 1'b0;
    endcase
    n_s = res_s[WIDTH-1];
    z_s = (res_s == {WIDTH{1'b0}});
  end

  // Accumulator value after the current multiply iteration
  always_comb begin
    if (mplr_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Handshake FSM, multiply iterations and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {(2*WIDTH){1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mplr_r    <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      out_valid <= 1'b0;
      ans_ex    <= {WIDTH{1'b0}};
      DM_data   <= {WIDTH{1'b0}};
      data_out  <= {WIDTH{1'b0}};
      flag_ex   <= 4'b0000;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            DM_data <= B;
            if (op_dec == OP_MUL) begin
              mcand_r <= {{WIDTH{1'b0}}, A};
              mplr_r  <= B;
              acc_r   <= {(2*WIDTH){1'b0}};
              cnt_r   <= CNT_W;
              state_r <= ST_MUL;
            end else begin
              out_valid <= 1'b1;
              if (ans_upd_s)   ans_ex   <= res_s;
              if (flags_upd_s) flag_ex  <= {n_s, c_s, z_s, v_s};
              if (out_op_s)    data_out <= A;
            end
          end
        end
        ST_MUL: begin
          acc_r   <= acc_nxt_s;
          mcand_r <= mcand_r << 1;
          mplr_r  <= mplr_r >> 1;
          cnt_r   <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b1;
            ans_ex    <= acc_nxt_s[WIDTH-1:0];
            flag_ex   <= {acc_nxt_s[WIDTH-1], 1'b0,
                          (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                          (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})};
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed self-checking bench for exec_unit_mc at WIDTH=16.
module tb_exec_unit_mc;

  localparam int W = 16;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_LD = 6'b001110,
                         OP_IN  = 6'b010000, OP_LS  = 6'b010001, OP_RS = 6'b010010,
                         OP_RSA = 6'b010011, OP_OUT = 6'b010110, OP_JZ = 6'b011010,
                         OP_MUL = 6'b100000, OP_BAD = 6'b111111;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   op_dec = 6'b000000;
  logic [W-1:0] A = 16'h0000, B = 16'h0000, data_in = 16'h0000;
  logic         out_valid;
  logic [W-1:0] ans_ex, DM_data, data_out;
  logic [3:0]   flag_ex;

  int checks = 0;
  int errors = 0;

  exec_unit_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_dec(op_dec), .A(A), .B(B), .data_in(data_in), .out_valid(out_valid),
    .ans_ex(ans_ex), .DM_data(DM_data), .data_out(data_out), .flag_ex(flag_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one edge; outputs are then sampled 1ns later.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op_dec   = op;
    A        = a;
    B        = b;
    step();
    in_valid = 1'b0;
  endtask

  // Wait for the MUL result; returns the number of edges after accept.
  task automatic wait_mul(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
      if (out_valid !== 1'b1) check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
    end
  endtask

  int n;
  int pulses;

  initial begin
    step();
    step();
    check("rst_ans", {16'd0, ans_ex}, 32'd0);
    check("rst_flags", {28'd0, flag_ex}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    step();

    issue(OP_ADD, 16'h7FFF, 16'h0001);
    check("add_ans", {16'd0, ans_ex}, 32'h8000);
    check("add_flags", {28'd0, flag_ex}, 32'b1001);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_dm", {16'd0, DM_data}, 32'h0001);
    step();
    check("add_valid_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back subtractions, one per cycle
    issue(OP_SUB, 16'h0005, 16'h0005);
    check("sub0_ans", {16'd0, ans_ex}, 32'h0000);
    check("sub0_flags", {28'd0, flag_ex}, 32'b0010);
    issue(OP_SUB, 16'h0003, 16'h0005);
    check("sub1_ans", {16'd0, ans_ex}, 32'hFFFE);
    check("sub1_flags", {28'd0, flag_ex}, 32'b1100);
    check("sub1_valid", {31'd0, out_valid}, 32'd1);

    issue(OP_SUB, 16'h0005, 16'h0005);
    issue(OP_JZ, 16'h00AA, 16'h0055);
    check("jz_ans", {16'd0, ans_ex}, 32'h0000);
    check("jz_flags", {28'd0, flag_ex}, 32'b0010);
    issue(OP_OUT, 16'h1234, 16'h0000);
    check("out_ans", {16'd0, ans_ex}, 32'h0000);
    check("out_flags", {28'd0, flag_ex}, 32'b0010);
    check("out_data", {16'd0, data_out}, 32'h1234);
    check("out_valid", {31'd0, out_valid}, 32'd1);

    // MUL with an ADD held on the inputs while busy; the ADD goes in afterwards
    issue(OP_MUL, 16'h0007, 16'h0006);
    check("mul_ready_low", {31'd0, in_ready}, 32'd0);
    check("mul_dm", {16'd0, DM_data}, 32'h0006);
    in_valid = 1'b1; op_dec = OP_ADD; A = 16'h0001; B = 16'h0001;
    wait_mul(n);
    check("mul_latency", n, 32'd16);
    check("mul_ans", {16'd0, ans_ex}, 32'h002A);
    check("mul_flags", {28'd0, flag_ex}, 32'b0000);
    check("mul_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("held_add_ans", {16'd0, ans_ex}, 32'h0002);
    check("held_add_valid", {31'd0, out_valid}, 32'd1);

    issue(OP_MUL, 16'h0100, 16'h0100);
    wait_mul(n);
    check("mul2_latency", n, 32'd16);
    check("mul2_ans", {16'd0, ans_ex}, 32'h0000);
    check("mul2_flags", {28'd0, flag_ex}, 32'b0011);

    issue(OP_RSA, 16'h8000, 16'd20);
    check("rsa_big", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b1000, 16'hFFFF});
    issue(OP_LS, 16'h0001, 16'd16);
    check("ls_w", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0010, 16'h0000});
    issue(OP_RS, 16'h0003, 16'd1);
    check("rs_1", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0100, 16'h0001});
    issue(OP_LS, 16'h8001, 16'd1);
    check("ls_1", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0100, 16'h0002});
    issue(OP_RSA, 16'h8000, 16'd16);
    check("rsa_w", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b1000, 16'hFFFF});
    issue(OP_RS, 16'h8001, 16'd16);
    check("rs_w", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0110, 16'h0000});
    issue(OP_RSA, 16'hF000, 16'd4);
    check("rsa_4", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b1000, 16'hFF00});

    issue(OP_ADD, 16'h0002, 16'h0003);
    check("add23", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0000, 16'h0005});
    issue(OP_BAD, 16'h1111, 16'h2222);
    check("undef", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b0000, 16'h0000});
    check("undef_valid", {31'd0, out_valid}, 32'd1);
    issue(OP_SUB, 16'h0000, 16'h0001);
    issue(OP_LD, 16'h0000, 16'h0000);
    check("ld", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b1100, 16'h0000});
    data_in = 16'hBEEF;
    issue(OP_IN, 16'h0000, 16'h0000);
    check("in", {12'd0, flag_ex, ans_ex}, {12'd0, 4'b1000, 16'hBEEF});

    // Reset in the middle of a MUL aborts it silently
    issue(OP_MUL, 16'h0007, 16'h0006);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    check("abort_ans", {16'd0, ans_ex}, 32'd0);
    check("abort_flags", {28'd0, flag_ex}, 32'd0);
    check("abort_dm", {16'd0, DM_data}, 32'd0);
    check("abort_dout", {16'd0, data_out}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    issue(OP_ADD, 16'h0002, 16'h0003);
    check("post_rst_add", {16'd0, ans_ex}, 32'h0005);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
Parametrised, handshaked successor to the single-cycle execution stage.
- Executes the team's 6-bit ISA opcodes on WIDTH-bit operands.
- Adds carry and negative flags, and out-of-range shift handling.
- Adds an iterative multi-cycle MUL that stalls the decode stage through in_ready.
- Sits between the decoder/register-read stage and the memory/writeback stage.

Parameters:
WIDTH, 16, datapath width in bits (must be ≥4).
SHW, $clog2(WIDTH), number of low B bits treated as the in-range shift amount.

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-low
in_valid  in  1  op_dec/A/B/data_in valid this cycle
in_ready  out  1  unit can accept an operation
op_dec  in  6  opcode (team ISA encoding; MUL = 6'b100000)
A  in  WIDTH  operand A
B  in  WIDTH  operand B / immediate / shift amount
data_in  in  WIDTH  external input port value for IN
out_valid  out  1  one-cycle pulse: ans_ex/flag_ex updated
ans_ex  out  WIDTH  registered result
DM_data  out  WIDTH  registered store data (B at accept)
data_out  out  WIDTH  registered output port, written only by OUT
flag_ex  out  4  {N,C,Z,V}, registered

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; state IDLE; in_ready=1 on the following cycle.
- Reset has priority over everything, including an in-flight MUL, which is aborted with no out_valid.
- Accept condition: accept = in_valid && in_ready. in_ready=1 only in IDLE.
- Single-cycle ops, on the accept edge:
  - ans_ex, flags, DM_data=B, and data_out (OUT only) are updated.
  - out_valid=1 for the next cycle only.
- Results:
  - ADD/ADI: A+B. SUB/SBI: A-B.
  - MOV/MVI: B. NOT/NTI: ~B.
  - AND/ANI, OR/ORI, XOR/XRI: bitwise.
  - LD/ST: A. IN: data_in.
  - LS/RS: logical shift. RSA: arithmetic shift.
- Shift amount: if B ≥ WIDTH, LS/RS give 0 and RSA gives WIDTH copies of A[MSB]. Otherwise the amount is B[SHW-1:0].
- Hold ops (RET, HLT, OUT, JMP, JV, JNV, JZ, JNZ): ans_ex and all flags unchanged. OUT sets data_out=A.
- Flag rules:
  - V: ADD = operands' signs equal and result sign differs. SUB = A sign ≠ B sign and result sign ≠ A sign. MUL = upper WIDTH bits of the 2·WIDTH product ≠ 0. Otherwise 0.
  - C: ADD carry-out; SUB borrow (A<B unsigned); shifts = last bit shifted out (0 when B==0, 0 when B>WIDTH, A[MSB]/A[0] when B==WIDTH); otherwise 0.
  - Z: result==0. N: result MSB.
- LD/ST update ans_ex but hold all flags.
- Undefined opcode: ans_ex=0, flags held, out_valid still pulses.
- MUL FSM, states IDLE → MUL → IDLE:
  - On accept, latch multiplicand A, multiplier B, clear the 2·WIDTH accumulator, load count=WIDTH, in_ready→0.
  - Each MUL cycle: if multiplier LSB is set, add the shifted multiplicand; shift; decrement count.
  - When the last iteration completes, ans_ex = low WIDTH bits and flags are set; out_valid=1 exactly WIDTH cycles after the accept edge; return to IDLE.
  - in_ready returns to 1 in the same cycle as out_valid.
  - The product is unsigned.
  - DM_data=B on the accept edge.
- Back-to-back single-cycle ops are allowed every cycle, giving throughput 1.
- in_valid while in_ready=0 is ignored; the upstream stage must hold its operation.

Test Plan:
- WIDTH=16, ADD A=0x7FFF, B=0x0001 → next cycle ans_ex=0x8000, {N,C,Z,V}=1001, out_valid=1 for exactly one cycle.
- SUB 0x0005−0x0005 → ans_ex=0, Z=1, C=0. Next cycle SUB 0x0003−0x0005 → 0xFFFE, N=1, C=1, V=0.
- MUL 0x0007×0x0006 → in_ready=0 for 16 cycles, ans_ex=0x002A at the 16th edge, V=0. Then MUL 0x0100×0x0100 → ans_ex=0x0000, Z=1, V=1.
- RSA A=0x8000, B=20 → 0xFFFF, N=1. LS A=0x0001, B=16 → 0x0000, Z=1, C=0. RS A=0x0003, B=1 → 0x0001, C=1.
- After SUB giving Z=1, issue JZ, then OUT with A=0x1234 → ans_ex and flags unchanged, data_out=0x1234.
- Start MUL, assert reset=0 at the 5th cycle → next cycle all outputs 0, in_ready=1, no out_valid. A subsequent ADD 2+3 gives 0x0005.
